multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have this parameter: STATE_W, 4, width of the state register and of the debug state output.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset; 0 = in reset.
REQ-005 opcode  in  7  inst[6:0] from the instruction register.
REQ-006 alu_bcond  in  1  ALU branch-condition result.
REQ-007 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-008 halt_req  in  1  the datapath asserts this when the instruction is ecall and x17 == 10.
REQ-009 mem_read, mem_write  out  1  memory request strobes.
REQ-010 i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 ir_write, mdr_write  out  1  instruction register and memory data register load enables.
REQ-012 reg_write  out  1  register-file write enable.
REQ-013 mem_to_reg  out  2  rd source: 0 = ALUOut, 1 = MDR, 2 = live ALU result.
REQ-014 alu_src_a  out  1  ALU input A: 0 = PC, 1 = A register.
REQ-015 alu_src_b  out  2  ALU input B: 0 = B register, 1 = constant 4, 2 = immediate.
REQ-016 alu_op_sel  out  2  0 = ADD, 1 = funct-decoded, 2 = branch compare.
REQ-017 pc_write  out  1  PC load enable.
REQ-018 pc_source  out  1  PC source: 0 = live ALU result, 1 = ALUOut.
REQ-019 is_halted  out  1  the processor is halted.
REQ-020 state  out  STATE_W  current state, for debug.
REQ-021 inst_count  out  32  count of retired instructions.

Function
REQ-022 The controller SHALL be a Moore FSM except for the outputs gated by mem_ready and alu_bcond. States: FETCH, DECODE, EX_R, EX_I, EX_ADDR, EX_BR, EX_JAL, EX_JALR, JALR_TGT, JUMP, MEM_RD, MEM_WR, WB_ALU, WB_MEM, PC_INC, ECALL, HALT.
REQ-023 FETCH SHALL assert mem_read=1 and i_or_d=0. ir_write SHALL equal mem_ready. The FSM SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-024 DECODE SHALL drive alu_src_a=0, alu_src_b=2, alu_op_sel=0 (ALUOut <= PC+imm). The next state SHALL be selected by opcode:
- R -> EX_R
- I-ALU -> EX_I
- load/store -> EX_ADDR
- branch -> EX_BR
- JAL -> EX_JAL
- JALR -> EX_JALR
- ecall -> ECALL
- any other opcode -> PC_INC (NOP)
REQ-025 EX_R SHALL drive alu_src_a=1, alu_src_b=0, alu_op_sel=1. EX_I SHALL drive the same with alu_src_b=2. Both SHALL go to WB_ALU.
REQ-026 EX_ADDR SHALL drive alu_src_a=1, alu_src_b=2, alu_op_sel=0, then go to MEM_RD for a load or MEM_WR for a store.
REQ-027 MEM_RD SHALL hold mem_read=1 and i_or_d=1 with mdr_write=mem_ready, and SHALL go to WB_MEM on mem_ready.
REQ-028 MEM_WR SHALL hold mem_write=1 and i_or_d=1. On mem_ready it SHALL also write PC+4 (pc_write=1, pc_source=0, alu_src_a=0, alu_src_b=1, ADD) and go to FETCH.
REQ-029 WB_ALU and WB_MEM SHALL assert reg_write=1 with mem_to_reg=0 or 1 respectively, SHALL write PC+4 in the same cycle, and SHALL go to FETCH.
REQ-030 EX_BR SHALL drive alu_src_a=1, alu_src_b=0, alu_op_sel=2.
- alu_bcond=1: pc_write=1, pc_source=1, next state FETCH.
- alu_bcond=0: next state PC_INC.
REQ-031 EX_JAL and EX_JALR SHALL drive the ALU to PC+4 and assert reg_write=1 with mem_to_reg=2. EX_JAL SHALL go to JUMP; EX_JALR SHALL go to JALR_TGT.
REQ-032 JUMP SHALL assert pc_write=1 with pc_source=1.
REQ-033 JALR_TGT SHALL drive ALU = A+imm and assert pc_write=1 with pc_source=0. Clearing bit 0 of the target is the datapath's job. rd==rs1 is safe because A was latched in DECODE.
REQ-034 PC_INC SHALL write PC+4 and go to FETCH.
REQ-035 ECALL SHALL go to HALT if halt_req=1, otherwise to PC_INC.
REQ-036 HALT SHALL be absorbing. In HALT, is_halted=1 and all write and request strobes SHALL be 0.
REQ-037 inst_count SHALL increment by 1 on every clock edge at which pc_write=1. It SHALL wrap modulo 2^32 and SHALL NOT increment in HALT.
REQ-038 In any state, every output not named for that state SHALL be 0.

Reset
REQ-039 While reset=0, the state SHALL be FETCH and inst_count SHALL be 0. All outputs SHALL be 0, including mem_read, which is gated by reset.
REQ-040 Reset asserted mid-instruction, including while waiting on mem_ready, SHALL abort the instruction with no further strobes.
REQ-041 The first FETCH request SHALL issue in the first cycle after reset deasserts.

Structure
REQ-042 The opcode constants, the state encoding, and the mux-select codes (mem_to_reg, alu_src_b, alu_op_sel, pc_source) SHALL live in a shared package used by the datapath.
REQ-043 One sub-module SHALL exist: controller_next_state, a purely combinational function (state, opcode, mem_ready, alu_bcond, halt_req) -> next state.

Verification
REQ-044 add (R-type) with mem_ready tied to 1: FETCH, DECODE, EX_R, WB_ALU. reg_write is high one cycle, mem_to_reg=0, pc_write in WB_ALU, inst_count 0->1, 4 cycles total.
REQ-045 lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD: mem_read is held 4 cycles in each. ir_write and mdr_write pulse exactly once each. Total 11 cycles.
REQ-046 beq with alu_bcond=1: the path is FETCH, DECODE, EX_BR, then FETCH with pc_write and pc_source=1. With alu_bcond=0: EX_BR, PC_INC, with pc_source=0.
REQ-047 jal followed by jalr: reg_write with mem_to_reg=2 in EX_JAL and EX_JALR; pc_write with pc_source=1 in JUMP and pc_source=0 in JALR_TGT.
REQ-048 ecall with halt_req=1: state reaches HALT, is_halted=1 held for 100 cycles, no strobes, inst_count frozen. ecall with halt_req=0: PC_INC, continue.
REQ-049 Reset pulled low in MEM_WR while mem_ready=0: all outputs 0 in the same cycle. After release, the state is FETCH and inst_count is 0.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// rtl/multi_cycle_controller_pkg.sv - shared opcodes, state encoding, mux codes and Moore output table
//
// Purpose: single source of truth for the controller and the datapath that
// consumes its mux selects. No ports (package).
package multi_cycle_controller_pkg;

   // RV32I major opcodes (inst[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // mem_to_reg
   localparam logic [1:0] MTR_ALUOUT = 2'd0;
   localparam logic [1:0] MTR_MDR    = 2'd1;
   localparam logic [1:0] MTR_ALU    = 2'd2;

   // alu_src_a
   localparam logic SRCA_PC = 1'b0;
   localparam logic SRCA_A  = 1'b1;

   // alu_src_b
   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   // alu_op_sel
   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_FUNCT = 2'd1;
   localparam logic [1:0] ALUOP_BR    = 2'd2;

   // pc_source
   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // 17 states need 5 bits; HALT is the only code above 15.
   typedef enum logic [4:0] {
      S_FETCH    = 5'd0,
      S_DECODE   = 5'd1,
      S_EX_R     = 5'd2,
      S_EX_I     = 5'd3,
      S_EX_ADDR  = 5'd4,
      S_EX_BR    = 5'd5,
      S_EX_JAL   = 5'd6,
      S_EX_JALR  = 5'd7,
      S_JALR_TGT = 5'd8,
      S_JUMP     = 5'd9,
      S_MEM_RD   = 5'd10,
      S_MEM_WR   = 5'd11,
      S_WB_ALU   = 5'd12,
      S_WB_MEM   = 5'd13,
      S_PC_INC   = 5'd14,
      S_ECALL    = 5'd15,
      S_HALT     = 5'd16
   } state_e;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op_sel;
      logic       pc_write;
      logic       pc_source;
      logic       is_halted;
   } ctl_t;

   // Moore part of the outputs. The mem_ready / alu_bcond dependent strobes
   // are added on top of this in the top level.
   function automatic ctl_t moore_outs(input state_e s);
      ctl_t o;
      o = '0;
      case (s)
         S_FETCH: begin
            o.mem_read = 1'b1;
         end
         S_DECODE: begin
            o.alu_src_a  = SRCA_PC;
            o.alu_src_b  = SRCB_IMM;
            o.alu_op_sel = ALUOP_ADD;
         end
         S_EX_R: begin
            o.alu_src_a  = SRCA_A;
            o.alu_src_b  = SRCB_B;
            o.alu_op_sel = ALUOP_FUNCT;
         end
         S_EX_I: begin
            o.alu_src_a  = SRCA_A;
            o.alu_src_b  = SRCB_IMM;
            o.alu_op_sel = ALUOP_FUNCT;
         end
         S_EX_ADDR: begin
            o.alu_src_a  = SRCA_A;
            o.alu_src_b  = SRCB_IMM;
            o.alu_op_sel = ALUOP_ADD;
         end
         S_EX_BR: begin
            o.alu_src_a  = SRCA_A;
            o.alu_src_b  = SRCB_B;
            o.alu_op_sel = ALUOP_BR;
         end
         S_EX_JAL, S_EX_JALR: begin
            o.alu_src_a  = SRCA_PC;
            o.alu_src_b  = SRCB_FOUR;
            o.alu_op_sel = ALUOP_ADD;
            o.reg_write  = 1'b1;
            o.mem_to_reg = MTR_ALU;
         end
         S_JALR_TGT: begin
            o.alu_src_a  = SRCA_A;
            o.alu_src_b  = SRCB_IMM;
            o.alu_op_sel = ALUOP_ADD;
            o.pc_write   = 1'b1;
            o.pc_source  = PCSRC_ALU;
         end
         S_JUMP: begin
            o.pc_write  = 1'b1;
            o.pc_source = PCSRC_ALUOUT;
         end
         S_MEM_RD: begin
            o.mem_read = 1'b1;
            o.i_or_d   = 1'b1;
         end
         S_MEM_WR: begin
            o.mem_write = 1'b1;
            o.i_or_d    = 1'b1;
         end
         S_WB_ALU, S_WB_MEM: begin
            o.reg_write  = 1'b1;
            o.mem_to_reg = (s == S_WB_MEM) ? MTR_MDR : MTR_ALUOUT;
            o.alu_src_a  = SRCA_PC;
            o.alu_src_b  = SRCB_FOUR;
            o.alu_op_sel = ALUOP_ADD;
            o.pc_write   = 1'b1;
            o.pc_source  = PCSRC_ALU;
         end
         S_PC_INC: begin
            o.alu_src_a  = SRCA_PC;
            o.alu_src_b  = SRCB_FOUR;
            o.alu_op_sel = ALUOP_ADD;
            o.pc_write   = 1'b1;
            o.pc_source  = PCSRC_ALU;
         end
         S_HALT: begin
            o.is_halted = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/controller_next_state.sv
// rtl/controller_next_state.sv - combinational next-state function of the multi-cycle controller
//
// Purpose: maps (state, opcode, mem_ready, alu_bcond, halt_req) to the next state.
// Ports:
//   state_i      current state
//   opcode_i     inst[6:0]
//   mem_ready_i  memory completes this cycle
//   alu_bcond_i  branch condition
//   halt_req_i   ecall with x17 == 10
//   next_state_o next state
module controller_next_state
   import multi_cycle_controller_pkg::*;
(
   input  state_e     state_i,
   input  logic [6:0] opcode_i,
   input  logic       mem_ready_i,
   input  logic       alu_bcond_i,
   input  logic       halt_req_i,
   output state_e     next_state_o
);

   always_comb begin
      next_state_o = S_FETCH;
      case (state_i)
         S_FETCH:    next_state_o = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode_i)
               OP_R:              next_state_o = S_EX_R;
               OP_I:              next_state_o = S_EX_I;
               OP_LOAD, OP_STORE: next_state_o = S_EX_ADDR;
               OP_BRANCH:         next_state_o = S_EX_BR;
               OP_JAL:            next_state_o = S_EX_JAL;
               OP_JALR:           next_state_o = S_EX_JALR;
               OP_SYSTEM:         next_state_o = S_ECALL;
               default:           next_state_o = S_PC_INC;
            endcase
         end
         S_EX_R, S_EX_I: next_state_o = S_WB_ALU;
         // Only loads and stores reach EX_ADDR, so anything not a store is a load.
         S_EX_ADDR:  next_state_o = (opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   next_state_o = mem_ready_i ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   next_state_o = mem_ready_i ? S_FETCH : S_MEM_WR;
         S_EX_BR:    next_state_o = alu_bcond_i ? S_FETCH : S_PC_INC;
         S_EX_JAL:   next_state_o = S_JUMP;
         S_EX_JALR:  next_state_o = S_JALR_TGT;
         S_ECALL:    next_state_o = halt_req_i ? S_HALT : S_PC_INC;
         S_HALT:     next_state_o = S_HALT;
         S_WB_ALU, S_WB_MEM, S_PC_INC, S_JUMP, S_JALR_TGT: next_state_o = S_FETCH;
         default:    next_state_o = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle RV32 control FSM with retired-instruction counter
//
// Purpose: sequences FETCH/DECODE/EXECUTE/MEM/WB for a multi-cycle datapath.
// Ports:
//   clk, reset                 clock, async active-low reset
//   opcode, alu_bcond          decode and branch inputs
//   mem_ready, halt_req        memory handshake, ecall halt request
//   mem_read, mem_write, i_or_d, ir_write, mdr_write, reg_write, mem_to_reg,
//   alu_src_a, alu_src_b, alu_op_sel, pc_write, pc_source  datapath controls
//   is_halted, state, inst_count  status and debug
module multi_cycle_controller
   import multi_cycle_controller_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode,
   input  logic               alu_bcond,
   input  logic               mem_ready,
   input  logic               halt_req,
   output logic               mem_read,
   output logic               mem_write,
   output logic               i_or_d,
   output logic               ir_write,
   output logic               mdr_write,
   output logic               reg_write,
   output logic [1:0]         mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op_sel,
   output logic               pc_write,
   output logic               pc_source,
   output logic               is_halted,
   output logic [STATE_W-1:0] state,
   output logic [31:0]        inst_count
);

   state_e      state_q;
   state_e      state_d;
   ctl_t        outs_q;
   logic [31:0] inst_count_q;

   controller_next_state u_next_state (
      .state_i      (state_q),
      .opcode_i     (opcode),
      .mem_ready_i  (mem_ready),
      .alu_bcond_i  (alu_bcond),
      .halt_req_i   (halt_req),
      .next_state_o (state_d)
   );

   // Moore outputs are registered alongside the state so they leave flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_FETCH;
         outs_q       <= moore_outs(S_FETCH);
         inst_count_q <= '0;
      end else begin
         state_q <= state_d;
         outs_q  <= moore_outs(state_d);
         if (pc_write) begin
            inst_count_q <= inst_count_q + 32'd1;
         end
      end
   end

   // Mealy overlays on mem_ready / alu_bcond, then a reset gate so that every
   // strobe (including FETCH's mem_read) drops in the same cycle reset falls.
   always_comb begin
      mem_read   = outs_q.mem_read;
      mem_write  = outs_q.mem_write;
      i_or_d     = outs_q.i_or_d;
      ir_write   = (state_q == S_FETCH) && mem_ready;
      mdr_write  = (state_q == S_MEM_RD) && mem_ready;
      reg_write  = outs_q.reg_write;
      mem_to_reg = outs_q.mem_to_reg;
      alu_src_a  = outs_q.alu_src_a;
      alu_src_b  = outs_q.alu_src_b;
      alu_op_sel = outs_q.alu_op_sel;
      pc_write   = outs_q.pc_write;
      pc_source  = outs_q.pc_source;
      is_halted  = outs_q.is_halted;

      // Store completes: PC <= PC + 4 in the same cycle.
      if ((state_q == S_MEM_WR) && mem_ready) begin
         pc_write   = 1'b1;
         pc_source  = PCSRC_ALU;
         alu_src_a  = SRCA_PC;
         alu_src_b  = SRCB_FOUR;
         alu_op_sel = ALUOP_ADD;
      end

      // Taken branch: PC <= ALUOut (PC + imm computed in DECODE).
      if ((state_q == S_EX_BR) && alu_bcond) begin
         pc_write  = 1'b1;
         pc_source = PCSRC_ALUOUT;
      end

      if (!reset) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         i_or_d     = 1'b0;
         ir_write   = 1'b0;
         mdr_write  = 1'b0;
         reg_write  = 1'b0;
         mem_to_reg = '0;
         alu_src_a  = 1'b0;
         alu_src_b  = '0;
         alu_op_sel = '0;
         pc_write   = 1'b0;
         pc_source  = 1'b0;
         is_halted  = 1'b0;
      end
   end

   // With the default STATE_W of 4, HALT aliases to FETCH here; is_halted
   // disambiguates. A width of 5 shows the full encoding.
   assign state      = STATE_W'(state_q);
   assign inst_count = inst_count_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - table-driven bench for multi_cycle_controller
module tb_multi_cycle_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  opcode = '0;
   logic        alu_bcond = 1'b0;
   logic        mem_ready = 1'b0;
   logic        halt_req = 1'b0;
   logic        mem_read, mem_write, i_or_d, ir_write, mdr_write, reg_write;
   logic [1:0]  mem_to_reg, alu_src_b, alu_op_sel;
   logic        alu_src_a, pc_write, pc_source, is_halted;
   logic [4:0]  state;
   logic [31:0] inst_count;

   multi_cycle_controller #(.STATE_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .alu_bcond  (alu_bcond),
      .mem_ready  (mem_ready),
      .halt_req   (halt_req),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .i_or_d     (i_or_d),
      .ir_write   (ir_write),
      .mdr_write  (mdr_write),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op_sel (alu_op_sel),
      .pc_write   (pc_write),
      .pc_source  (pc_source),
      .is_halted  (is_halted),
      .state      (state),
      .inst_count (inst_count)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, SYS = 7'b1110011;

   // Output bit flags: {mr,mw,iod,irw,mdrw,rw,mtr[1:0],sa,sb[1:0],op[1:0],pw,ps,h}
   localparam logic [15:0] MR = 16'h8000, MW = 16'h4000, IOD = 16'h2000, IRW = 16'h1000;
   localparam logic [15:0] MDRW = 16'h0800, RW = 16'h0400, MTR2 = 16'h0200, MTR1 = 16'h0100;
   localparam logic [15:0] SA = 16'h0080, SB2 = 16'h0040, SB1 = 16'h0020;
   localparam logic [15:0] OP2 = 16'h0010, OP1 = 16'h0008, PW = 16'h0004, PS = 16'h0002, H = 16'h0001;

   typedef struct {
      logic [6:0]  op;
      logic        mr;
      logic        bc;
      logic        hr;
      logic [4:0]  st;
      logic [15:0] o;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [6:0] op, input logic mr, input logic bc, input logic hr,
                               input logic [4:0] st, input logic [15:0] o, input logic [31:0] cnt);
      vec_t v;
      v.op = op; v.mr = mr; v.bc = bc; v.hr = hr; v.st = st; v.o = o; v.cnt = cnt;
      return v;
   endfunction

   task automatic add_v(input logic [6:0] op, input logic mr, input logic bc, input logic hr,
                        input logic [4:0] st, input logic [15:0] o, input logic [31:0] cnt);
      tbl.push_back(mk(op, mr, bc, hr, st, o, cnt));
   endtask

   function automatic logic [15:0] act_o();
      return {mem_read, mem_write, i_or_d, ir_write, mdr_write, reg_write, mem_to_reg,
              alu_src_a, alu_src_b, alu_op_sel, pc_write, pc_source, is_halted};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] o, input logic [4:0] st, input logic [31:0] cnt);
      check({tag, " outputs"}, 32'(act_o()), 32'(o));
      check({tag, " state"}, 32'(state), 32'(st));
      check({tag, " inst_count"}, inst_count, cnt);
   endtask

   // Called just after a falling edge; leaves just after the next falling edge.
   task automatic run_vec(input vec_t v, input string tag);
      opcode = v.op; mem_ready = v.mr; alu_bcond = v.bc; halt_req = v.hr;
      #2;
      check_all(tag, v.o, v.st, v.cnt);
      @(negedge clk);
   endtask

   initial begin
      // add, mem_ready tied high
      add_v(R, 1,0,0, 0,  MR|IRW, 0);
      add_v(R, 1,0,0, 1,  SB2, 0);
      add_v(R, 1,0,0, 2,  SA|OP1, 0);
      add_v(R, 1,0,0, 12, RW|PW|SB1, 0);
      // lw, 3 wait cycles in FETCH and MEM_RD
      for (int k = 0; k < 3; k++) add_v(LD, 0,0,0, 0, MR, 1);
      add_v(LD, 1,0,0, 0,  MR|IRW, 1);
      add_v(LD, 1,0,0, 1,  SB2, 1);
      add_v(LD, 1,0,0, 4,  SA|SB2, 1);
      for (int k = 0; k < 3; k++) add_v(LD, 0,0,0, 10, MR|IOD, 1);
      add_v(LD, 1,0,0, 10, MR|IOD|MDRW, 1);
      add_v(LD, 1,0,0, 13, RW|MTR1|PW|SB1, 1);
      // sw, one wait cycle in MEM_WR
      add_v(ST, 1,0,0, 0,  MR|IRW, 2);
      add_v(ST, 1,0,0, 1,  SB2, 2);
      add_v(ST, 1,0,0, 4,  SA|SB2, 2);
      add_v(ST, 0,0,0, 11, MW|IOD, 2);
      add_v(ST, 1,0,0, 11, MW|IOD|PW|SB1, 2);
      // beq taken
      add_v(BR, 1,1,0, 0,  MR|IRW, 3);
      add_v(BR, 1,1,0, 1,  SB2, 3);
      add_v(BR, 1,1,0, 5,  SA|OP2|PW|PS, 3);
      // beq not taken
      add_v(BR, 1,0,0, 0,  MR|IRW, 4);
      add_v(BR, 1,0,0, 1,  SB2, 4);
      add_v(BR, 1,0,0, 5,  SA|OP2, 4);
      add_v(BR, 1,0,0, 14, PW|SB1, 4);
      // addi
      add_v(I, 1,0,0, 0,  MR|IRW, 5);
      add_v(I, 1,0,0, 1,  SB2, 5);
      add_v(I, 1,0,0, 3,  SA|SB2|OP1, 5);
      add_v(I, 1,0,0, 12, RW|PW|SB1, 5);
      // jal then jalr
      add_v(JAL, 1,0,0, 0, MR|IRW, 6);
      add_v(JAL, 1,0,0, 1, SB2, 6);
      add_v(JAL, 1,0,0, 6, SB1|RW|MTR2, 6);
      add_v(JAL, 1,0,0, 9, PW|PS, 6);
      add_v(JALR, 1,0,0, 0, MR|IRW, 7);
      add_v(JALR, 1,0,0, 1, SB2, 7);
      add_v(JALR, 1,0,0, 7, SB1|RW|MTR2, 7);
      add_v(JALR, 1,0,0, 8, SA|SB2|PW, 7);
      // unknown opcode is a NOP
      add_v(7'h00, 1,0,0, 0,  MR|IRW, 8);
      add_v(7'h00, 1,0,0, 1,  SB2, 8);
      add_v(7'h00, 1,0,0, 14, PW|SB1, 8);
      // ecall without halt
      add_v(SYS, 1,0,0, 0,  MR|IRW, 9);
      add_v(SYS, 1,0,0, 1,  SB2, 9);
      add_v(SYS, 1,0,0, 15, 16'h0, 9);
      add_v(SYS, 1,0,0, 14, PW|SB1, 9);
      // ecall with halt
      add_v(SYS, 1,0,1, 0,  MR|IRW, 10);
      add_v(SYS, 1,0,1, 1,  SB2, 10);
      add_v(SYS, 1,0,1, 15, 16'h0, 10);
      add_v(SYS, 1,0,1, 16, H, 10);

      // Reset state, including mem_read gated off
      repeat (3) @(negedge clk);
      mem_ready = 1'b1;
      #2;
      check_all("reset", 16'h0, 5'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // HALT absorbs for 100 cycles whatever the inputs do
      for (int i = 0; i < 100; i++) begin
         run_vec(mk(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'd16, H, 32'd10),
                 $sformatf("halt%0d", i));
      end

      // Reset out of HALT
      reset = 1'b0;
      #2;
      check_all("halt reset", 16'h0, 5'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // add again, then a store stuck in MEM_WR gets reset
      for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("re-add%0d", i));
      run_vec(mk(ST, 1,0,0, 0,  MR|IRW, 1), "sw fetch");
      run_vec(mk(ST, 1,0,0, 1,  SB2, 1), "sw decode");
      run_vec(mk(ST, 1,0,0, 4,  SA|SB2, 1), "sw addr");
      run_vec(mk(ST, 0,0,0, 11, MW|IOD, 1), "sw wait");
      mem_ready = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      check_all("mid reset", 16'h0, 5'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check_all("reset hold", 16'h0, 5'd0, 32'd0);
      reset = 1'b1;
      run_vec(mk(ST, 0,0,0, 0, MR, 0), "post-reset fetch");
      run_vec(mk(ST, 1,0,0, 0, MR|IRW, 0), "post-reset fetch ready");
      run_vec(mk(ST, 1,0,0, 1, SB2, 0), "post-reset decode");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
